// File: rtl/fg_pkg.sv
// Shared constants for the function-generator DAC write path: FSM encoding,
// default DAC timing and the width helper used to size the phase counters.
package fg_pkg;

  localparam logic [1:0] FG_ST_IDLE  = 2'd0;
  localparam logic [1:0] FG_ST_SETUP = 2'd1;
  localparam logic [1:0] FG_ST_PULSE = 2'd2;
  localparam logic [1:0] FG_ST_HOLD  = 2'd3;

  localparam int FG_DAC_SETUP = 1;
  localparam int FG_DAC_PULSE = 2;
  localparam int FG_DAC_HOLD  = 1;
  localparam int FG_DAC_CLR   = 4;

  function automatic int fg_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/fg_dac_timer.sv
// Loadable down-counter with a zero flag; one instance times the setup,
// pulse and hold phases of every DAC write.
module fg_dac_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fg_dac_write_sequencer.sv
// Turns core sample strobes into timed parallel-DAC writes (setup, WR low,
// hold) with a one-deep pending slot, plus the DAC clear and power-down lines.
module fg_dac_write_sequencer
  import fg_pkg::*;
#(
  parameter int BITWIDTH     = 8,
  parameter int SETUP_CYCLES = FG_DAC_SETUP,
  parameter int PULSE_CYCLES = FG_DAC_PULSE,
  parameter int HOLD_CYCLES  = FG_DAC_HOLD,
  parameter int CLR_CYCLES   = FG_DAC_CLR
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [BITWIDTH-1:0] data_i,
  input  logic                valid_strb_i,
  output logic [BITWIDTH-1:0] dac_data_o,
  output logic                dac_wr_n_o,
  output logic                dac_pd_n_o,
  output logic                dac_clr_n_o,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam int CNT_W = $clog2(fg_max3(fg_max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES),
                                        CLR_CYCLES, 0) + 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYCLES);

  logic [1:0]          state_q, state_d;
  logic                tmr_zero, tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                accept, hold_last, send_pend;
  logic                load_data;
  logic [BITWIDTH-1:0] load_src;
  logic [BITWIDTH-1:0] pend_q, pend_d;
  logic                pend_full_q, pend_full_d;
  logic [BITWIDTH-1:0] dac_data_q, dac_data_d;
  logic                wr_n_q, wr_n_d;
  logic                pd_n_q, pd_n_d;
  logic                clr_n_q, clr_n_d;
  logic                overrun_q, overrun_d;
  logic [CNT_W-1:0]    clr_cnt_q, clr_cnt_d;

  assign accept    = valid_strb_i & enable_i & clr_n_q;
  assign hold_last = (state_q == FG_ST_HOLD) & tmr_zero;
  // A pending sample dropped by disable must never reach the DAC.
  assign send_pend = hold_last & pend_full_q & enable_i;

  fg_dac_timer #(.W(CNT_W)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FG_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_data = 1'b0;
    load_src  = data_i;
    case (state_q)
      FG_ST_IDLE: begin
        if (accept) begin
          state_d   = FG_ST_SETUP;
          load_data = 1'b1;
        end
      end
      FG_ST_SETUP: if (tmr_zero) state_d = FG_ST_PULSE;
      FG_ST_PULSE: if (tmr_zero) state_d = FG_ST_HOLD;
      FG_ST_HOLD: begin
        if (tmr_zero) begin
          if (send_pend) begin
            state_d   = FG_ST_SETUP;
            load_data = 1'b1;
            load_src  = pend_q;
          end else if (accept) begin
            state_d   = FG_ST_SETUP;
            load_data = 1'b1;
          end else begin
            state_d = FG_ST_IDLE;
          end
        end
      end
      default: state_d = FG_ST_IDLE;
    endcase
  end

  always_comb begin
    // The timer reloads on every phase boundary and continuously while idle.
    tmr_load = (state_q == FG_ST_IDLE) | tmr_zero;
    case (state_d)
      FG_ST_SETUP: tmr_val = SETUP_LD;
      FG_ST_PULSE: tmr_val = PULSE_LD;
      FG_ST_HOLD:  tmr_val = HOLD_LD;
      default:     tmr_val = '0;
    endcase
    dac_data_d = load_data ? load_src : dac_data_q;
    wr_n_d     = (state_d != FG_ST_PULSE);
    pd_n_d     = enable_i ? 1'b1 : ((state_d == FG_ST_IDLE) ? 1'b0 : pd_n_q);
    clr_cnt_d  = (clr_cnt_q != '0) ? clr_cnt_q - CNT_W'(1) : clr_cnt_q;
    clr_n_d    = (clr_cnt_q <= CNT_W'(1));

    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    overrun_d   = 1'b0;
    if (!enable_i) begin
      pend_full_d = 1'b0;
    end else if (hold_last) begin
      // Last hold cycle: an empty slot lets the strobe go straight out.
      if (pend_full_q) begin
        if (accept) begin
          pend_d = data_i;
        end else begin
          pend_full_d = 1'b0;
        end
      end
    end else if ((state_q != FG_ST_IDLE) && accept) begin
      pend_d      = data_i;
      pend_full_d = 1'b1;
      overrun_d   = pend_full_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dac_data_q  <= '0;
      wr_n_q      <= 1'b1;
      pd_n_q      <= 1'b0;
      clr_n_q     <= 1'b0;
      overrun_q   <= 1'b0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      clr_cnt_q   <= CLR_LD;
    end else begin
      dac_data_q  <= dac_data_d;
      wr_n_q      <= wr_n_d;
      pd_n_q      <= pd_n_d;
      clr_n_q     <= clr_n_d;
      overrun_q   <= overrun_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end

  assign dac_data_o  = dac_data_q;
  assign dac_wr_n_o  = wr_n_q;
  assign dac_pd_n_o  = pd_n_q;
  assign dac_clr_n_o = clr_n_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != FG_ST_IDLE);

endmodule
